// File: rtl/frame_buffer_ctrl_pkg.sv
// Shared geometry, RGB packing offsets and write-FSM encoding for the LED-matrix frame buffer.
package frame_buffer_ctrl_pkg;

    localparam int unsigned FB_ROW_NUM = 8;
    localparam int unsigned FB_COL_NUM = 8;
    localparam int unsigned FB_RGB_W   = 3;
    localparam int unsigned FB_ROW_W   = FB_COL_NUM * FB_RGB_W;
    localparam int unsigned FB_IDX_W   = 3;

    localparam int unsigned FB_OFS_R = 0;
    localparam int unsigned FB_OFS_G = 1;
    localparam int unsigned FB_OFS_B = 2;

    typedef enum logic [1:0] {
        FB_IDLE      = 2'd0,
        FB_CLEAR     = 2'd1,
        FB_WAIT_SWAP = 2'd2
    } fb_state_e;

endpackage

// File: rtl/frame_buffer_ctrl_bank.sv
// One 8x24 RGB register bank: pixel write port, row clear port, combinational row read.
module fb_bank
    import frame_buffer_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                i_wr_en,
    input  logic [FB_IDX_W-1:0] i_wr_row,
    input  logic [FB_IDX_W-1:0] i_wr_col,
    input  logic [FB_RGB_W-1:0] i_wr_rgb,
    input  logic                i_clr_en,
    input  logic [FB_IDX_W-1:0] i_clr_row,
    input  logic [FB_IDX_W-1:0] i_rd_row,
    output logic [FB_ROW_W-1:0] o_rd_data_c
);

    logic [FB_ROW_W-1:0] r_mem [FB_ROW_NUM];
    logic [4:0]          w_bit_base;

    assign w_bit_base  = 5'(i_wr_col) * 5'd3;
    assign o_rd_data_c = r_mem[i_rd_row];

    // Clear wins over write; the controller never asserts both, this just keeps it defined.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < FB_ROW_NUM; r++) begin
                r_mem[r] <= '0;
            end
        end else if (i_clr_en) begin
            r_mem[i_clr_row] <= '0;
        end else if (i_wr_en) begin
            r_mem[i_wr_row][w_bit_base +: FB_RGB_W] <= i_wr_rgb;
        end
    end

endmodule

// File: rtl/frame_buffer_ctrl.sv
// Double-buffered 8x8 RGB frame memory: source writes the back bank, scanner reads the front,
// banks swap only on a scanner frame boundary after the source marks its frame complete.
module frame_buffer_ctrl
    import frame_buffer_ctrl_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_valid_i,
    output logic                wr_ready_o,
    input  logic [2:0]          wr_x_i,
    input  logic [2:0]          wr_y_i,
    input  logic [2:0]          wr_rgb_i,
    input  logic                wr_last_i,
    input  logic                clear_i,
    input  logic                frame_start_i,
    input  logic                rd_req_i,
    input  logic [2:0]          rd_row_i,
    output logic [FB_ROW_W-1:0] rd_data_o,
    output logic                rd_valid_o,
    output logic                front_sel_o,
    output logic                swap_o
);

    fb_state_e           r_state;
    fb_state_e           w_state_nxt;
    logic [FB_IDX_W-1:0] r_clr_row;
    logic                r_front_sel;
    logic [FB_ROW_W-1:0] r_rd_data;
    logic                r_rd_valid;
    logic                r_swap;

    logic                w_wr_fire;
    logic                w_clr_en;
    logic                w_swap_nxt;
    logic [FB_ROW_W-1:0] w_rd_bank0;
    logic [FB_ROW_W-1:0] w_rd_bank1;
    logic [FB_ROW_W-1:0] w_rd_front;

    assign wr_ready_o  = (r_state == FB_IDLE) && !clear_i && !rst_i;
    assign w_wr_fire   = wr_valid_i && wr_ready_o;
    assign w_rd_front  = r_front_sel ? w_rd_bank1 : w_rd_bank0;

    assign rd_data_o   = r_rd_data;
    assign rd_valid_o  = r_rd_valid;
    assign front_sel_o = r_front_sel;
    assign swap_o      = r_swap;

    // Writes and clears only ever target the bank that is not displayed.
    fb_bank u_bank0 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_wr_en     (w_wr_fire && r_front_sel),
        .i_wr_row    (wr_y_i),
        .i_wr_col    (wr_x_i),
        .i_wr_rgb    (wr_rgb_i),
        .i_clr_en    (w_clr_en && r_front_sel),
        .i_clr_row   (r_clr_row),
        .i_rd_row    (rd_row_i),
        .o_rd_data_c (w_rd_bank0)
    );

    fb_bank u_bank1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_wr_en     (w_wr_fire && !r_front_sel),
        .i_wr_row    (wr_y_i),
        .i_wr_col    (wr_x_i),
        .i_wr_rgb    (wr_rgb_i),
        .i_clr_en    (w_clr_en && !r_front_sel),
        .i_clr_row   (r_clr_row),
        .i_rd_row    (rd_row_i),
        .o_rd_data_c (w_rd_bank1)
    );

    // Write-side FSM: next state, clear strobe and swap request.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_en    = 1'b0;
        w_swap_nxt  = 1'b0;
        unique case (r_state)
            FB_IDLE: begin
                if (clear_i) begin
                    w_state_nxt = FB_CLEAR;
                end else if (w_wr_fire && wr_last_i) begin
                    w_state_nxt = FB_WAIT_SWAP;
                end
            end
            FB_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_row == FB_IDX_W'(FB_ROW_NUM - 1)) begin
                    w_state_nxt = FB_IDLE;
                end
            end
            FB_WAIT_SWAP: begin
                if (frame_start_i) begin
                    w_swap_nxt  = 1'b1;
                    w_state_nxt = FB_IDLE;
                end
            end
            default: begin
                w_state_nxt = FB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= FB_IDLE;
            r_clr_row   <= '0;
            r_front_sel <= 1'b0;
            r_swap      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_row   <= w_clr_en ? r_clr_row + FB_IDX_W'(1) : '0;
            r_front_sel <= r_front_sel ^ w_swap_nxt;
            r_swap      <= w_swap_nxt;
        end
    end

    // Read port samples the pre-swap front bank on the swap edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_req_i;
            if (rd_req_i) begin
                r_rd_data <= w_rd_front;
            end
        end
    end

endmodule
